// File: rtl/vga_scaler_out_if.sv
// Frame-buffer read port between the VGA scaler (master) and the frame buffer (slave).
// The scaler issues a registered address/strobe and receives an RGB332 word back.
interface vga_scaler_out_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [7:0]        fb_data;

    modport master (
        output fb_addr,
        output fb_rd_en,
        input  fb_data
    );

    modport slave (
        input  fb_addr,
        input  fb_rd_en,
        output fb_data
    );
endinterface

// File: rtl/vga_scaler_out.sv
// VGA raster generator that fetches a line-replicated image from a frame buffer,
// surrounds it with a border colour and emits pipeline-aligned rgb/sync outputs.
module vga_scaler_out #(
    parameter int         H_BORDER   = 32,
    parameter int         H_IMG      = 256,
    parameter int         H_FP       = 8,
    parameter int         H_SYNC     = 48,
    parameter int         H_BP       = 24,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33,
    parameter int         IMG_LINES  = 240,
    parameter int         V_SCALE    = 2,
    parameter int         MEM_LAT    = 1,
    parameter logic       SYNC_ACT   = 1'b0,
    parameter logic [8:0] BORDER_RGB = 9'h000,
    parameter int         ADDR_W     = 16
) (
    input  logic                    pix_clk,
    input  logic                    rst_n,
    vga_scaler_out_if.master        fb,
    output logic [8:0]              rgb,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    vblank,
    output logic                    frame_start
);

    localparam int H_TOT       = 2*H_BORDER + H_IMG + H_FP + H_SYNC + H_BP;
    localparam int V_TOT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW          = $clog2(H_TOT + 1);
    localparam int VW          = $clog2(V_TOT + 1);
    localparam int RW          = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam int FETCH_LINES = (IMG_LINES*V_SCALE < V_ACTIVE) ? IMG_LINES*V_SCALE : V_ACTIVE;

    localparam logic [HW-1:0]     H_LAST    = HW'(H_TOT - 1);
    localparam logic [HW-1:0]     H_IMG_LO  = HW'(H_BORDER);
    localparam logic [HW-1:0]     H_IMG_HI  = HW'(H_BORDER + H_IMG);
    localparam logic [HW-1:0]     H_VIS     = HW'(2*H_BORDER + H_IMG);
    localparam logic [HW-1:0]     HS_LO     = HW'(2*H_BORDER + H_IMG + H_FP);
    localparam logic [HW-1:0]     HS_HI     = HW'(2*H_BORDER + H_IMG + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST    = VW'(V_TOT - 1);
    localparam logic [VW-1:0]     V_FETCH   = VW'(FETCH_LINES);
    localparam logic [VW-1:0]     V_VIS     = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_LO     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_HI     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [RW-1:0]     REP_LAST  = RW'(V_SCALE - 1);
    localparam logic [ADDR_W-1:0] IMG_STEP  = ADDR_W'(H_IMG);

    if ((V_SCALE < 1) || (V_SCALE > 4)) begin : g_bad_scale
        $error("vga_scaler_out: V_SCALE must be 1..4");
    end
    if ((MEM_LAT < 0) || (MEM_LAT > 3)) begin : g_bad_lat
        $error("vga_scaler_out: MEM_LAT must be 0..3");
    end
    if (longint'(IMG_LINES) * longint'(H_IMG) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("vga_scaler_out: image does not fit in ADDR_W address space");
    end

    typedef struct packed {
        logic fetch;
        logic visible;
        logic hs;
        logic vs;
        logic vb;
        logic fs;
    } ctrl_t;

    function automatic logic [8:0] rgb332_to_rgb333(input logic [7:0] d);
        return {d[7:5], d[4:2], d[1:0], d[1]};
    endfunction

    logic [HW-1:0]     h_cnt_r;
    logic [VW-1:0]     v_cnt_r;
    logic [RW-1:0]     rep_r;
    logic [ADDR_W-1:0] row_base_r;

    logic [HW-1:0]     h_nxt_s;
    logic [VW-1:0]     v_nxt_s;
    logic [RW-1:0]     rep_nxt_s;
    logic [ADDR_W-1:0] base_nxt_s;
    logic [HW-1:0]     col_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              fetch_nxt_s;
    logic              h_wrap_s;
    logic              v_wrap_s;

    ctrl_t ctrl_s;
    ctrl_t ctrl_d_s;

    // Next raster position; the source row advances as a base address every V_SCALE lines.
    always_comb begin
        h_wrap_s   = (h_cnt_r == H_LAST);
        v_wrap_s   = (v_cnt_r == V_LAST);
        h_nxt_s    = h_cnt_r + HW'(1);
        v_nxt_s    = v_cnt_r;
        rep_nxt_s  = rep_r;
        base_nxt_s = row_base_r;
        if (h_wrap_s) begin
            h_nxt_s = '0;
            if (v_wrap_s) begin
                v_nxt_s    = '0;
                rep_nxt_s  = '0;
                base_nxt_s = '0;
            end else if (rep_r == REP_LAST) begin
                v_nxt_s    = v_cnt_r + VW'(1);
                rep_nxt_s  = '0;
                base_nxt_s = row_base_r + IMG_STEP;
            end else begin
                v_nxt_s    = v_cnt_r + VW'(1);
                rep_nxt_s  = rep_r + RW'(1);
                base_nxt_s = row_base_r;
            end
        end else begin
            h_nxt_s = h_cnt_r + HW'(1);
        end
    end

    // Fetch decision for the next position, so the registered address lines up with the counters.
    always_comb begin
        fetch_nxt_s = (h_nxt_s >= H_IMG_LO) && (h_nxt_s < H_IMG_HI) && (v_nxt_s < V_FETCH);
        col_nxt_s   = h_nxt_s - H_IMG_LO;
        addr_nxt_s  = base_nxt_s + ADDR_W'(col_nxt_s);
    end

    // Raster, replication and row-base counters.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            h_cnt_r    <= '0;
            v_cnt_r    <= '0;
            rep_r      <= '0;
            row_base_r <= '0;
        end else begin
            h_cnt_r    <= h_nxt_s;
            v_cnt_r    <= v_nxt_s;
            rep_r      <= rep_nxt_s;
            row_base_r <= base_nxt_s;
        end
    end

    // Frame-buffer read port; the address holds its last value outside the image.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            fb.fb_rd_en <= 1'b0;
            fb.fb_addr  <= '0;
        end else if (fetch_nxt_s) begin
            fb.fb_rd_en <= 1'b1;
            fb.fb_addr  <= addr_nxt_s;
        end else begin
            fb.fb_rd_en <= 1'b0;
        end
    end

    // Per-pixel control flags decoded from the current counter values.
    always_comb begin
        ctrl_s.fetch   = (h_cnt_r >= H_IMG_LO) && (h_cnt_r < H_IMG_HI) && (v_cnt_r < V_FETCH);
        ctrl_s.visible = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        ctrl_s.hs      = (h_cnt_r >= HS_LO) && (h_cnt_r < HS_HI);
        ctrl_s.vs      = (v_cnt_r >= VS_LO) && (v_cnt_r < VS_HI);
        ctrl_s.vb      = (v_cnt_r >= V_VIS);
        ctrl_s.fs      = (h_cnt_r == '0) && (v_cnt_r == '0);
    end

    // Control flags wait MEM_LAT clocks so they meet the returning pixel at the output register.
    if (MEM_LAT == 0) begin : g_no_pipe
        assign ctrl_d_s = ctrl_s;
    end else begin : g_pipe
        ctrl_t pipe_r [MEM_LAT];

        // Control delay line.
        always_ff @(posedge pix_clk) begin
            if (!rst_n) begin
                for (int i = 0; i < MEM_LAT; i++) begin
                    pipe_r[i] <= '0;
                end
            end else begin
                pipe_r[0] <= ctrl_s;
                for (int i = 1; i < MEM_LAT; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        assign ctrl_d_s = pipe_r[MEM_LAT-1];
    end

    // Output register: colour select and sync levels.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            rgb         <= 9'h000;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (ctrl_d_s.fetch) begin
                rgb <= rgb332_to_rgb333(fb.fb_data);
            end else if (ctrl_d_s.visible) begin
                rgb <= BORDER_RGB;
            end else begin
                rgb <= 9'h000;
            end
            hsync       <= ctrl_d_s.hs ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= ctrl_d_s.vs ? SYNC_ACT : ~SYNC_ACT;
            vblank      <= ctrl_d_s.vb;
            frame_start <= ctrl_d_s.fs;
        end
    end

endmodule

// File: tb/tb_vga_scaler_out.sv
// Directed bench: a default-parameter scaler plus a small raster (MEM_LAT=3, SYNC_ACT=1,
// V_SCALE=1, padded lines) fed by frame-buffer models returning the low address byte.
module tb_vga_scaler_out;

    logic pix_clk = 1'b0;
    logic rst_n;

    always #40 pix_clk = ~pix_clk;

    vga_scaler_out_if #(.ADDR_W(16)) fb0 ();
    vga_scaler_out_if #(.ADDR_W(16)) fb1 ();

    logic [8:0] rgb0, rgb1;
    logic       hs0, vs0, vb0, fs0;
    logic       hs1, vs1, vb1, fs1;

    vga_scaler_out u_dut0 (
        .pix_clk     (pix_clk),
        .rst_n       (rst_n),
        .fb          (fb0.master),
        .rgb         (rgb0),
        .hsync       (hs0),
        .vsync       (vs0),
        .vblank      (vb0),
        .frame_start (fs0)
    );

    // Small raster: H_TOT=24 (image h 4..11, visible h<16, hsync h 18..20),
    // V_TOT=10 (image v 0..3, padding v 4..5, vsync v 7..8).
    vga_scaler_out #(
        .H_BORDER(4), .H_IMG(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_LINES(4), .V_SCALE(1), .MEM_LAT(3),
        .SYNC_ACT(1'b1), .BORDER_RGB(9'h1A5), .ADDR_W(16)
    ) u_dut1 (
        .pix_clk     (pix_clk),
        .rst_n       (rst_n),
        .fb          (fb1.master),
        .rgb         (rgb1),
        .hsync       (hs1),
        .vsync       (vs1),
        .vblank      (vb1),
        .frame_start (fs1)
    );

    // Frame-buffer models: data = low byte of the address, MEM_LAT clocks later.
    logic [7:0] m1_q1, m1_q2;
    always @(posedge pix_clk) begin
        fb0.fb_data <= fb0.fb_addr[7:0];
        m1_q1       <= fb1.fb_addr[7:0];
        m1_q2       <= m1_q1;
        fb1.fb_data <= m1_q2;
    end

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pix_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    int hs0_low, hs0_first, vs0_low, vb0_hi, fs0_cnt;
    int hs1_hi, vs1_hi, vb1_hi, fs1_cnt, rd1_cnt;

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_rgb0",   32'(rgb0), 32'd0);
        chk("rst_hs0",    32'(hs0), 32'd1);
        chk("rst_vs0",    32'(vs0), 32'd1);
        chk("rst_vb0",    32'(vb0), 32'd0);
        chk("rst_fs0",    32'(fs0), 32'd0);
        chk("rst_rd0",    32'(fb0.fb_rd_en), 32'd0);
        chk("rst_addr0",  32'(fb0.fb_addr), 32'd0);
        chk("rst_hs1",    32'(hs1), 32'd0);
        chk("rst_vs1",    32'(vs1), 32'd0);

        rst_n = 1'b1;
        cyc = 0;
        hs0_low = 0; hs0_first = 0; vs0_low = 0; vb0_hi = 0; fs0_cnt = 0;
        hs1_hi = 0; vs1_hi = 0; vb1_hi = 0; fs1_cnt = 0; rd1_cnt = 0;

        for (int c = 1; c <= 500; c++) begin
            step();
            if (hs0 == 1'b0) begin
                hs0_low++;
                if (hs0_first == 0) hs0_first = cyc;
            end
            if (vs0 == 1'b0) vs0_low++;
            if (vb0) vb0_hi++;
            if (fs0) fs0_cnt++;
            if (hs1) hs1_hi++;
            if (vs1) vs1_hi++;
            if (vb1) vb1_hi++;
            if (fs1) fs1_cnt++;
            if (fb1.fb_rd_en) rd1_cnt++;
            case (cyc)
                1:   chk("d0_fs_early", 32'(fs0), 32'd0);
                2:   chk("d0_fs_first", 32'(fs0), 32'd1);
                4:   begin
                         chk("d1_fs_first", 32'(fs1), 32'd1);
                         chk("d1_addr_v0h4", 32'(fb1.fb_addr), 32'd0);
                         chk("d1_rd_v0h4", 32'(fb1.fb_rd_en), 32'd1);
                     end
                7:   chk("d1_rgb_lborder", 32'(rgb1), 32'h1A5);
                8:   chk("d1_rgb_px0", 32'(rgb1), 32'h000);
                15:  chk("d1_rgb_px7", 32'(rgb1), 32'h00F);
                16:  chk("d1_rgb_rborder", 32'(rgb1), 32'h1A5);
                20:  chk("d1_rgb_hblank", 32'(rgb1), 32'h000);
                21:  chk("d1_hs_before", 32'(hs1), 32'd0);
                22:  chk("d1_hs_start", 32'(hs1), 32'd1);
                24:  chk("d1_hs_end", 32'(hs1), 32'd1);
                25:  chk("d1_hs_after", 32'(hs1), 32'd0);
                28:  chk("d1_addr_v1h4", 32'(fb1.fb_addr), 32'd8);
                31:  chk("d0_rd_h31", 32'(fb0.fb_rd_en), 32'd0);
                32:  begin
                         chk("d0_rd_h32", 32'(fb0.fb_rd_en), 32'd1);
                         chk("d0_addr_h32", 32'(fb0.fb_addr), 32'd0);
                         chk("d1_rgb_v1px0", 32'(rgb1), 32'h010);
                     end
                83:  chk("d1_addr_last", 32'(fb1.fb_addr), 32'd31);
                87:  chk("d1_rgb_last", 32'(rgb1), 32'h03F);
                100: begin
                         chk("d1_rd_pad", 32'(fb1.fb_rd_en), 32'd0);
                         chk("d1_addr_hold", 32'(fb1.fb_addr), 32'd31);
                     end
                105: chk("d1_rgb_pad", 32'(rgb1), 32'h1A5);
                153: chk("d1_rgb_vblank", 32'(rgb1), 32'h000);
                204: chk("d0_rgb_AA", 32'(rgb0), 32'h155);
                205: chk("d0_rgb_AB", 32'(rgb0), 32'h157);
                244: chk("d1_fs_second", 32'(fs1), 32'd1);
                287: begin
                         chk("d0_addr_h287", 32'(fb0.fb_addr), 32'd255);
                         chk("d0_rd_h287", 32'(fb0.fb_rd_en), 32'd1);
                     end
                288: begin
                         chk("d0_rd_h288", 32'(fb0.fb_rd_en), 32'd0);
                         chk("d0_addr_hold", 32'(fb0.fb_addr), 32'd255);
                     end
                289: chk("d0_rgb_FF", 32'(rgb0), 32'h1FF);
                290: chk("d0_rgb_rborder", 32'(rgb0), 32'h000);
                432: chk("d0_addr_v1h32", 32'(fb0.fb_addr), 32'd0);
                500: chk("d0_addr_v1h100", 32'(fb0.fb_addr), 32'd68);
                default: ;
            endcase
        end

        chk("d0_hs_width", 32'(hs0_low), 32'd48);
        chk("d0_hs_first", 32'(hs0_first), 32'd330);
        chk("d0_vs_quiet", 32'(vs0_low), 32'd0);
        chk("d0_vb_quiet", 32'(vb0_hi), 32'd0);
        chk("d0_fs_count", 32'(fs0_cnt), 32'd1);
        chk("d1_hs_count", 32'(hs1_hi), 32'd60);
        chk("d1_vs_count", 32'(vs1_hi), 32'd96);
        chk("d1_vb_count", 32'(vb1_hi), 32'd192);
        chk("d1_fs_count", 32'(fs1_cnt), 32'd3);
        chk("d1_rd_count", 32'(rd1_cnt), 32'd72);

        goto(832);
        chk("d0_addr_v2h32", 32'(fb0.fb_addr), 32'd256);
        goto(1005);
        chk("d0_rgb_v2", 32'(rgb0), 32'h157);
        goto(1487);
        chk("d0_addr_v3h287", 32'(fb0.fb_addr), 32'd511);
        goto(40150);
        chk("d0_addr_v100h150", 32'(fb0.fb_addr), 32'd12918);
        chk("d0_rd_v100h150", 32'(fb0.fb_rd_en), 32'd1);

        rst_n = 1'b0;
        step();
        chk("mid_rgb0",  32'(rgb0), 32'd0);
        chk("mid_hs0",   32'(hs0), 32'd1);
        chk("mid_vs0",   32'(vs0), 32'd1);
        chk("mid_fs0",   32'(fs0), 32'd0);
        chk("mid_rd0",   32'(fb0.fb_rd_en), 32'd0);
        chk("mid_addr0", 32'(fb0.fb_addr), 32'd0);
        chk("mid_hs1",   32'(hs1), 32'd0);
        rst_n = 1'b1;
        cyc = 0;

        for (int c = 1; c <= 40; c++) begin
            step();
            case (cyc)
                1:  chk("re_d0_fs_early", 32'(fs0), 32'd0);
                2:  chk("re_d0_fs", 32'(fs0), 32'd1);
                3:  chk("re_d1_fs_early", 32'(fs1), 32'd0);
                4:  chk("re_d1_fs", 32'(fs1), 32'd1);
                32: begin
                        chk("re_d0_rd_h32", 32'(fb0.fb_rd_en), 32'd1);
                        chk("re_d0_addr_h32", 32'(fb0.fb_addr), 32'd0);
                    end
                33: chk("re_d0_addr_h33", 32'(fb0.fb_addr), 32'd1);
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
